// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - mode constants and state encoding shared by the channel mux/scanner
package mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  localparam logic [0:0] ST_MANUAL = 1'b0;
  localparam logic [0:0] ST_SCAN   = 1'b1;

endpackage

// File: rtl/mux_scan_ctr.sv
// rtl/mux_scan_ctr.sv - scan pointer, dwell counter and wrap detection for mux_scan_nx1
module mux_scan_ctr #(
  parameter int N     = 4,
  parameter int DWELL = 2,
  parameter int SW    = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          step,
  input  logic          restart,
  input  logic          clear,
  output logic [SW-1:0] p,
  output logic          wrap_next
);

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SW-1:0] P_LAST = SW'(N - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DWELL - 1);

  logic [DW-1:0] d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p <= '0;
      d <= '0;
    end else if (clear) begin
      p <= '0;
      d <= '0;
    end else if (step) begin
      if (d == D_LAST) begin
        d <= '0;
        p <= (p == P_LAST) ? '0 : p + SW'(1);
      end else begin
        d <= d + DW'(1);
      end
    end
  end

  // p=0,d=0 inside SCAN is only reachable by rolling over from N-1; entry is excluded via restart
  assign wrap_next = step && !restart && (p == '0) && (d == '0);

endmodule

// File: rtl/mux_scan_nx1.sv
// rtl/mux_scan_nx1.sv - N-input registered mux with manual select and built-in round-robin scan
module mux_scan_nx1
  import mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int W     = 1,
  parameter int DWELL = 2,
  parameter int SW    = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  input  logic [N*W-1:0] din,
  output logic [W-1:0]   dout,
  output logic [SW-1:0]  ch,
  output logic           valid,
  output logic           wrap
);

  localparam logic [SW:0] NUM_CH = (SW + 1)'(N);

  logic [0:0]    state;
  logic          scan_step;
  logic          scan_restart;
  logic          man_clear;
  logic          wrap_next;
  logic          sel_ok;
  logic [SW-1:0] p;
  logic [SW-1:0] pick;
  logic [W-1:0]  pick_data;

  assign scan_step    = en && (mode == MODE_SCAN);
  assign scan_restart = scan_step && (state == ST_MANUAL);
  assign man_clear    = en && (mode == MODE_MANUAL);
  assign sel_ok       = ({1'b0, sel} < NUM_CH);
  assign pick         = (mode == MODE_SCAN) ? p : sel;

  mux_scan_ctr #(.N(N), .DWELL(DWELL), .SW(SW)) u_ctr (
    .clk       (clk),
    .rst_n     (rst_n),
    .step      (scan_step),
    .restart   (scan_restart),
    .clear     (man_clear),
    .p         (p),
    .wrap_next (wrap_next)
  );

  // out-of-range selects (non-power-of-two N) fall through to zero
  always_comb begin
    pick_data = '0;
    for (int k = 0; k < N; k++) begin
      if (pick == SW'(k)) pick_data = din[k*W +: W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_MANUAL;
      dout  <= '0;
      ch    <= '0;
      valid <= 1'b0;
      wrap  <= 1'b0;
    end else if (en) begin
      state <= (mode == MODE_SCAN) ? ST_SCAN : ST_MANUAL;
      dout  <= pick_data;
      ch    <= pick;
      valid <= (mode == MODE_SCAN) || sel_ok;
      wrap  <= wrap_next;
    end else begin
      valid <= 1'b0;
      wrap  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_scan_nx1.sv
// tb/tb_mux_scan_nx1.sv - self-checking bench for mux_scan_nx1 (N=4/W=1/DWELL=2 and N=3/W=8/DWELL=1)
module tb_mux_scan_nx1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        en4, mode4;
  logic [1:0]  sel4;
  logic [3:0]  din4;
  logic        dout4;
  logic [1:0]  ch4;
  logic        valid4, wrap4;

  logic        en3, mode3;
  logic [1:0]  sel3;
  logic [23:0] din3;
  logic [7:0]  dout3;
  logic [1:0]  ch3;
  logic        valid3, wrap3;

  mux_scan_nx1 #(.N(4), .W(1), .DWELL(2)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en4), .mode(mode4), .sel(sel4), .din(din4),
    .dout(dout4), .ch(ch4), .valid(valid4), .wrap(wrap4)
  );

  mux_scan_nx1 #(.N(3), .W(8), .DWELL(1)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en3), .mode(mode3), .sel(sel3), .din(din3),
    .dout(dout3), .ch(ch3), .valid(valid3), .wrap(wrap3)
  );

  int tests = 0;
  int fails = 0;

  int n_of[2]  = '{4, 3};
  int w_of[2]  = '{1, 8};
  int dw_of[2] = '{2, 1};

  bit m_scan[2];
  int m_k[2];
  int m_dout[2];
  int m_ch[2];
  int m_v[2];
  int m_w[2];

  int exp_ch_a[10]   = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
  int exp_dout_a[10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
  int exp_ch_b[4]    = '{0, 1, 2, 0};
  int exp_dout_b[4]  = '{'hA1, 'hB2, 'hC3, 'hA1};
  int exp_man_a[4]   = '{0, 0, 1, 1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_scan[i] = 1'b0;
      m_k[i] = 0;
      m_dout[i] = 0;
      m_ch[i] = 0;
      m_v[i] = 0;
      m_w[i] = 0;
    end
  endtask

  function automatic int chan(input int i, input logic [23:0] din, input int c);
    return (int'(din) >> (c * w_of[i])) & ((1 << w_of[i]) - 1);
  endfunction

  // k counts enabled scan samples since entry; channel and wrap follow from plain arithmetic on k
  task automatic model(input int i, input logic en, input logic mode, input int sel, input logic [23:0] din);
    int c;
    m_w[i] = 0;
    if (!en) begin
      m_v[i] = 0;
      return;
    end
    if (mode) begin
      if (!m_scan[i]) begin
        m_scan[i] = 1'b1;
        m_k[i] = 0;
      end
      c = (m_k[i] / dw_of[i]) % n_of[i];
      m_ch[i] = c;
      m_dout[i] = chan(i, din, c);
      m_v[i] = 1;
      m_w[i] = (m_k[i] > 0 && (m_k[i] % (n_of[i] * dw_of[i])) == 0) ? 1 : 0;
      m_k[i]++;
    end else begin
      m_scan[i] = 1'b0;
      m_ch[i] = sel;
      m_v[i] = (sel < n_of[i]) ? 1 : 0;
      m_dout[i] = m_v[i] ? chan(i, din, sel) : 0;
    end
  endtask

  task automatic cycle();
    if (rst_n) begin
      model(0, en4, mode4, int'(sel4), {20'd0, din4});
      model(1, en3, mode3, int'(sel3), din3);
    end else begin
      model_reset();
    end
    @(posedge clk);
    #1;
    check("a_dout", dout4, m_dout[0]);
    check("a_ch", ch4, m_ch[0]);
    check("a_valid", valid4, m_v[0]);
    check("a_wrap", wrap4, m_w[0]);
    check("b_dout", dout3, m_dout[1]);
    check("b_ch", ch3, m_ch[1]);
    check("b_valid", valid3, m_v[1]);
    check("b_wrap", wrap3, m_w[1]);
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    en3 = 1'b0; mode3 = 1'b0; sel3 = 2'd0; din3 = 24'd0;
    repeat (3) begin
      en4 = 1'($urandom); mode4 = 1'($urandom); sel4 = 2'($urandom); din4 = 4'($urandom);
      en3 = 1'($urandom); mode3 = 1'($urandom); sel3 = 2'($urandom); din3 = 24'($urandom);
      cycle();
    end
    rst_n = 1'b1;
    en3 = 1'b0;

    // manual select on the 4:1 instance
    en4 = 1'b1; mode4 = 1'b0; din4 = 4'b1100;
    for (int s = 0; s < 4; s++) begin
      sel4 = 2'(s);
      cycle();
      check("man_dout", dout4, exp_man_a[s]);
      check("man_ch", ch4, s);
    end

    // scan entry, full period plus wrap
    mode4 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("scan_ch", ch4, exp_ch_a[i]);
      check("scan_dout", dout4, exp_dout_a[i]);
      check("scan_wrap", wrap4, (i == 8) ? 1 : 0);
    end
    cycle();
    cycle();
    cycle();
    check("pre_gap_ch", ch4, 2);

    en4 = 1'b0;
    repeat (3) begin
      cycle();
      check("gap_valid", valid4, 0);
      check("gap_ch", ch4, 2);
    end
    en4 = 1'b1;
    cycle();
    check("resume_ch2", ch4, 2);
    cycle();
    check("resume_ch3", ch4, 3);

    // leave scan with sel=1, then re-enter
    din4 = 4'b0110;
    mode4 = 1'b0; sel4 = 2'd1;
    cycle();
    check("sw_man_ch", ch4, 1);
    check("sw_man_dout", dout4, 1);
    check("sw_man_wrap", wrap4, 0);
    mode4 = 1'b1;
    cycle();
    check("sw_scan_ch", ch4, 0);
    check("sw_scan_wrap", wrap4, 0);
    cycle();
    cycle();
    cycle();

    // asynchronous reset between edges
    #3;
    rst_n = 1'b0;
    #1;
    check("async_dout", dout4, 0);
    check("async_ch", ch4, 0);
    check("async_valid", valid4, 0);
    check("async_wrap", wrap4, 0);
    model_reset();
    cycle();
    rst_n = 1'b1;

    // 3-channel instance, DWELL=1
    en4 = 1'b0;
    en3 = 1'b1; mode3 = 1'b1; din3 = 24'hC3B2A1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("b_scan_ch", ch3, exp_ch_b[i]);
      check("b_scan_dout", dout3, exp_dout_b[i]);
      check("b_scan_wrap", wrap3, (i == 3) ? 1 : 0);
    end
    mode3 = 1'b0; sel3 = 2'd3;
    cycle();
    check("b_oor_valid", valid3, 0);
    check("b_oor_dout", dout3, 0);
    sel3 = 2'd2;
    cycle();
    check("b_man_dout", dout3, 'hC3);

    // randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      en4 = ($urandom_range(0, 3) != 0);
      en3 = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 5) == 0) mode4 = ~mode4;
      if ($urandom_range(0, 5) == 0) mode3 = ~mode3;
      sel4 = 2'($urandom);
      sel3 = 2'($urandom);
      din4 = 4'($urandom);
      din3 = 24'($urandom);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
